// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver FSM encoding and the
// control characters that the FIFO and command parser also recognise.
package uart_pkg;

   localparam int DATA_WIDTH = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP,
      BREAK = ST_BREAK
   } rx_state_t;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] BS = 8'h08;

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side bundle: serial pin in, byte/strobe/status out.
// master = the receiver itself, slave = whoever drives the pin and consumes bytes.
interface uart_receiver_if;
   import uart_pkg::*;

   logic                  iRXD;
   logic                  oDE;
   logic [DATA_WIDTH-1:0] oDATA;
   logic                  oFERR;
   logic                  oBUSY;

   modport master (input iRXD, output oDE, output oDATA, output oFERR, output oBUSY);
   modport slave  (output iRXD, input oDE, input oDATA, input oFERR, input oBUSY);

endinterface

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input pin.
// The reset value is a parameter so idle-high and idle-low pins can share it.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic CLK,
   input  logic RST,
   input  logic iD,
   output logic oQ
);

   logic meta;

   // Capture the pin, then give the first flop a full cycle to settle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         meta <= RESET_VAL;
         oQ   <= RESET_VAL;
      end else begin
         meta <= iD;
         oQ   <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling from a divided bit timer.
// Good frames give one byte with a one-cycle oDE; a low stop bit gives a
// one-cycle oFERR and the line must return high before a new start is taken.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic           CLK,
   input  logic           RST,
   uart_receiver_if.master bus
);

   localparam int DIV   = CLK_FREQ / BAUD_RATE;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = $clog2(DIV);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);

   generate
      if (DIV < 4) begin : g_div_check
         $error("uart_receiver: CLK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   rx_state_t             state, stateNext;
   logic [CNT_W-1:0]      bitCnt, bitCntNext;
   logic [2:0]            bitIdx, bitIdxNext;
   logic [DATA_WIDTH-1:0] shiftReg, shiftNext;
   logic [DATA_WIDTH-1:0] dataReg, dataNext;
   logic                  deReg, deNext;
   logic                  ferrReg, ferrNext;
   logic                  rxd;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .CLK (CLK),
      .RST (RST),
      .iD  (bus.iRXD),
      .oQ  (rxd)
   );

   // Register the FSM state together with the bit timer, shifter and outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         bitCnt   <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         dataReg  <= '0;
         deReg    <= 1'b0;
         ferrReg  <= 1'b0;
      end else begin
         state    <= stateNext;
         bitCnt   <= bitCntNext;
         bitIdx   <= bitIdxNext;
         shiftReg <= shiftNext;
         dataReg  <= dataNext;
         deReg    <= deNext;
         ferrReg  <= ferrNext;
      end
   end

   // Frame sequencing: start mid-point check, eight data samples, stop check,
   // and a break wait so a held-low line is never mistaken for a new start.
   always_comb begin
      stateNext  = state;
      bitCntNext = bitCnt;
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      dataNext   = dataReg;
      deNext     = 1'b0;
      ferrNext   = 1'b0;

      case (state)
         IDLE: begin
            if (!rxd) begin
               stateNext  = START;
               bitCntNext = '0;
            end
         end
         START: begin
            if (bitCnt == HALF_M1) begin
               bitCntNext = '0;
               if (!rxd) begin
                  stateNext  = DATA;
                  bitIdxNext = '0;
               end else begin
                  stateNext = IDLE;
               end
            end else begin
               bitCntNext = bitCnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bitCnt == DIV_M1) begin
               shiftNext[bitIdx] = rxd;
               bitCntNext        = '0;
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
               end else begin
                  bitIdxNext = bitIdx + 3'd1;
               end
            end else begin
               bitCntNext = bitCnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bitCnt == DIV_M1) begin
               bitCntNext = '0;
               if (rxd) begin
                  dataNext  = shiftReg;
                  deNext    = 1'b1;
                  stateNext = IDLE;
               end else begin
                  ferrNext  = 1'b1;
                  stateNext = BREAK;
               end
            end else begin
               bitCntNext = bitCnt + CNT_W'(1);
            end
         end
         BREAK: begin
            if (rxd) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign bus.oDE   = deReg;
   assign bus.oDATA = dataReg;
   assign bus.oFERR = ferrReg;
   assign bus.oBUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with DIV=16, HALF=8. Every frame pushes its
// expected strobe (kind, byte, cycle) to a scoreboard; a negedge monitor pops
// and compares whenever oDE or oFERR fires.
module tb_uart_receiver;
   import uart_pkg::*;

   localparam int TB_DIV  = 16;
   localparam int TB_HALF = 8;
   localparam int LAT     = 2 + TB_HALF + 9 * TB_DIV + 1;

   typedef struct {
      logic       isFerr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic CLK;
   logic RST;
   int   cyc;
   int   nAsserts;
   int   nFails;
   logic [7:0] lastData;
   exp_t sb[$];

   uart_receiver_if bus ();

   uart_receiver #(
      .CLK_FREQ  (1600000),
      .BAUD_RATE (100000)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // 10 ns clock with a free-running cycle counter for latency checks.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Drive one full frame; called just after a rising edge.
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
      exp_t e;
      e.isFerr = !stopBit;
      e.data   = stopBit ? b : lastData;
      e.cyc    = cyc + LAT;
      sb.push_back(e);
      if (stopBit) lastData = b;
      bus.iRXD = 1'b0;
      waitCycles(TB_DIV);
      for (int i = 0; i < 8; i++) begin
         bus.iRXD = b[i];
         waitCycles(TB_DIV);
      end
      bus.iRXD = stopBit;
      waitCycles(TB_DIV);
   endtask

   // Scoreboard monitor: every strobe must match the oldest expectation.
   always @(negedge CLK) begin
      if (bus.oDE === 1'b1 || bus.oFERR === 1'b1) begin
         exp_t e;
         checkOutput("exclusiveStrobes", {31'b0, bus.oDE & bus.oFERR}, 32'd0);
         checkOutput("strobeExpected", {31'b0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("strobeKindFerr", {31'b0, bus.oFERR}, {31'b0, e.isFerr});
            checkOutput("strobeData", {24'b0, bus.oDATA}, {24'b0, e.data});
            checkOutput("strobeCycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      nAsserts = 0;
      nFails   = 0;
      lastData = 8'h00;
      RST      = 1'b0;
      bus.iRXD = 1'b1;

      // 1. Asynchronous reset mid-cycle.
      waitCycles(2);
      #3 RST = 1'b1;
      #1;
      checkOutput("rstDE", {31'b0, bus.oDE}, 32'd0);
      checkOutput("rstFERR", {31'b0, bus.oFERR}, 32'd0);
      checkOutput("rstDATA", {24'b0, bus.oDATA}, 32'd0);
      checkOutput("rstBUSY", {31'b0, bus.oBUSY}, 32'd0);
      waitCycles(3);
      RST = 1'b0;
      waitCycles(4);
      checkOutput("postRstBUSY", {31'b0, bus.oBUSY}, 32'd0);

      // 2. Single frame 0x41.
      applyStimulus(8'h41, 1'b1);
      waitCycles(10);
      checkOutput("frame41Drained", sb.size(), 32'd0);
      checkOutput("frame41Hold", {24'b0, bus.oDATA}, 32'h41);

      // 3. Back-to-back 0x0A then 0x55.
      applyStimulus(LF, 1'b1);
      applyStimulus(8'h55, 1'b1);
      waitCycles(10);
      checkOutput("b2bDrained", sb.size(), 32'd0);
      checkOutput("b2bHold", {24'b0, bus.oDATA}, 32'h55);

      // 4. Five-clock glitch is rejected.
      bus.iRXD = 1'b0;
      waitCycles(4);
      checkOutput("glitchBusy", {31'b0, bus.oBUSY}, 32'd1);
      waitCycles(1);
      bus.iRXD = 1'b1;
      waitCycles(8);
      checkOutput("glitchIdle", {31'b0, bus.oBUSY}, 32'd0);
      waitCycles(20);
      checkOutput("glitchNoStrobe", sb.size(), 32'd0);
      checkOutput("glitchHold", {24'b0, bus.oDATA}, {24'b0, lastData});

      // 5. Framing error followed by a 40-clock break.
      applyStimulus(8'hC3, 1'b0);
      waitCycles(38);
      checkOutput("breakBusy", {31'b0, bus.oBUSY}, 32'd1);
      waitCycles(2);
      bus.iRXD = 1'b1;
      waitCycles(1);
      checkOutput("breakBusyUntilHigh", {31'b0, bus.oBUSY}, 32'd1);
      waitCycles(3);
      checkOutput("breakReleased", {31'b0, bus.oBUSY}, 32'd0);
      waitCycles(200);
      checkOutput("breakNoSpurious", {31'b0, bus.oBUSY}, 32'd0);
      checkOutput("ferrDrained", sb.size(), 32'd0);
      checkOutput("ferrHold", {24'b0, bus.oDATA}, {24'b0, lastData});

      // 6. Reset during bit 4 aborts the frame, then 0x7E is received.
      bus.iRXD = 1'b0;
      waitCycles(TB_DIV);
      for (int i = 0; i < 4; i++) begin
         bus.iRXD = i[0];
         waitCycles(TB_DIV);
      end
      bus.iRXD = 1'b1;
      waitCycles(8);
      checkOutput("abortBusyBefore", {31'b0, bus.oBUSY}, 32'd1);
      #3 RST = 1'b1;
      #1;
      checkOutput("abortBusy", {31'b0, bus.oBUSY}, 32'd0);
      checkOutput("abortDATA", {24'b0, bus.oDATA}, 32'd0);
      lastData = 8'h00;
      waitCycles(3);
      RST = 1'b0;
      waitCycles(TB_DIV * 12);
      checkOutput("abortNoStrobe", sb.size(), 32'd0);
      applyStimulus(8'h7E, 1'b1);
      waitCycles(10);
      checkOutput("frame7EDrained", sb.size(), 32'd0);
      checkOutput("frame7EHold", {24'b0, bus.oDATA}, 32'h7E);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
